harmonic_sequencer: RTL and testbench

//  Frame scheduler for the additive-synthesis datapath: runs one pass over all harmonics per sample period.
//  For each harmonic it sequences the scale multiplier, sample-position lookup and odd/even adders.
//  It latches accumulator totals and triggers the DAC at a fixed sample-rate tick.

---
 rtl/harmonic_sequencer_if.sv | 30 +++
 rtl/harmonic_sequencer.sv | 163 ++++++++++++++++
 tb/tb_harmonic_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/harmonic_sequencer_if.sv
// rtl/harmonic_sequencer_if.sv - handshake bundle between the frame scheduler and the synthesis datapath
interface harmonic_sequencer_if;
  logic       i_Sample_Ready;
  logic       i_Freq_Too_High;
  logic       i_Mult_Ready;
  logic       i_Comb_Muted;
  logic       i_Comb_Enable;
  logic [7:0] o_Harmonic;
  logic       o_Next_Sample;
  logic       o_Start_Mult;
  logic       o_Restart_Mult;
  logic [1:0] o_Adder_Start;
  logic       o_Adder_Clear;
  logic       o_Latch_Totals;
  logic       o_DAC_Send;
  logic       o_Overrun;
  logic       o_Busy;

  modport master (
    input  i_Sample_Ready, i_Freq_Too_High, i_Mult_Ready, i_Comb_Muted, i_Comb_Enable,
    output o_Harmonic, o_Next_Sample, o_Start_Mult, o_Restart_Mult, o_Adder_Start,
           o_Adder_Clear, o_Latch_Totals, o_DAC_Send, o_Overrun, o_Busy
  );

  modport slave (
    output i_Sample_Ready, i_Freq_Too_High, i_Mult_Ready, i_Comb_Muted, i_Comb_Enable,
    input  o_Harmonic, o_Next_Sample, o_Start_Mult, o_Restart_Mult, o_Adder_Start,
           o_Adder_Clear, o_Latch_Totals, o_DAC_Send, o_Overrun, o_Busy
  );
endinterface

// File: rtl/harmonic_sequencer.sv
// rtl/harmonic_sequencer.sv - per-sample frame scheduler for the additive-synthesis harmonic loop
module harmonic_sequencer #(
  parameter logic [7:0]  NO_OF_HARMONICS = 8'd50,
  parameter logic [15:0] SAMPLEINTERVAL  = 16'd1000
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  harmonic_sequencer_if.master  bus
);

  localparam logic [7:0]  LAST_HARMONIC = NO_OF_HARMONICS - 8'd1;
  localparam logic [15:0] LAST_COUNT    = SAMPLEINTERVAL - 16'd1;

  typedef enum logic [2:0] {
    S_WAIT_TICK,
    S_SEND,
    S_MULT,
    S_MULT_WAIT,
    S_WAIT_SAMPLE,
    S_ADD,
    S_NEXT,
    S_DONE
  } state_t;

  state_t     state, state_d;
  logic [7:0] harmonic, harmonic_d;
  logic       abort_flag, abort_flag_d;
  logic       tick_pending, tick_pending_d;
  logic [15:0] timer;
  logic       tick;

  logic       next_sample_q;
  logic       start_mult_q;
  logic       restart_mult_q;
  logic [1:0] adder_start_q;
  logic       adder_clear_q;
  logic       latch_totals_q;
  logic       dac_send_q;
  logic       overrun_q;
  logic       busy_q;

  // Sample-rate timer runs independently of the FSM so the DAC cadence is fixed.
  assign tick = (timer == LAST_COUNT);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      timer <= 16'd0;
    end else if (tick) begin
      timer <= 16'd0;
    end else begin
      timer <= timer + 16'd1;
    end
  end

  always_comb begin
    state_d        = state;
    harmonic_d     = harmonic;
    abort_flag_d   = abort_flag;
    tick_pending_d = tick_pending;
    case (state)
      S_WAIT_TICK: begin
        if (tick || tick_pending) begin
          state_d        = S_SEND;
          tick_pending_d = 1'b0;
        end
      end
      S_SEND: state_d = S_MULT;
      S_DONE: begin
        if (abort_flag) begin
          state_d = S_SEND;
        end else begin
          state_d        = S_WAIT_TICK;
          tick_pending_d = tick;
        end
      end
      default: begin
        // A tick inside the harmonic loop abandons the frame ahead of any other transition.
        if (tick) begin
          state_d      = S_DONE;
          abort_flag_d = 1'b1;
        end else begin
          case (state)
            S_MULT: state_d = S_MULT_WAIT;
            S_MULT_WAIT: begin
              if (bus.i_Mult_Ready) begin
                if (bus.i_Comb_Enable && bus.i_Comb_Muted && (harmonic != 8'd0)) begin
                  state_d = S_NEXT;
                end else begin
                  state_d = S_WAIT_SAMPLE;
                end
              end
            end
            S_WAIT_SAMPLE: begin
              if (bus.i_Sample_Ready) begin
                state_d = S_ADD;
              end
            end
            S_ADD: state_d = S_NEXT;
            S_NEXT: begin
              if ((harmonic == LAST_HARMONIC) || bus.i_Freq_Too_High) begin
                state_d = S_DONE;
              end else begin
                harmonic_d = harmonic + 8'd1;
                state_d    = S_MULT;
              end
            end
            default: state_d = S_WAIT_TICK;
          endcase
        end
      end
    endcase
    if (state_d == S_SEND) begin
      harmonic_d   = 8'd0;
      abort_flag_d = 1'b0;
    end
  end

  // Outputs are registered from the state being entered, so each pulse lines up with its state.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state          <= S_WAIT_TICK;
      harmonic       <= 8'd0;
      abort_flag     <= 1'b0;
      tick_pending   <= 1'b0;
      next_sample_q  <= 1'b0;
      start_mult_q   <= 1'b0;
      restart_mult_q <= 1'b0;
      adder_start_q  <= 2'b00;
      adder_clear_q  <= 1'b0;
      latch_totals_q <= 1'b0;
      dac_send_q     <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state          <= state_d;
      harmonic       <= harmonic_d;
      abort_flag     <= abort_flag_d;
      tick_pending   <= tick_pending_d;
      next_sample_q  <= (state_d == S_SEND) || ((state == S_NEXT) && (state_d == S_MULT));
      start_mult_q   <= (state_d == S_MULT);
      restart_mult_q <= (state_d == S_SEND);
      adder_start_q  <= (state_d != S_ADD) ? 2'b00 : (harmonic_d[0] ? 2'b10 : 2'b01);
      adder_clear_q  <= (state_d == S_DONE);
      latch_totals_q <= (state_d == S_DONE);
      dac_send_q     <= (state_d == S_SEND);
      overrun_q      <= (state_d == S_SEND) && abort_flag;
      busy_q         <= (state_d == S_MULT) || (state_d == S_MULT_WAIT) ||
                        (state_d == S_WAIT_SAMPLE) || (state_d == S_ADD) || (state_d == S_NEXT);
    end
  end

  assign bus.o_Harmonic     = harmonic;
  assign bus.o_Next_Sample  = next_sample_q;
  assign bus.o_Start_Mult   = start_mult_q;
  assign bus.o_Restart_Mult = restart_mult_q;
  assign bus.o_Adder_Start  = adder_start_q;
  assign bus.o_Adder_Clear  = adder_clear_q;
  assign bus.o_Latch_Totals = latch_totals_q;
  assign bus.o_DAC_Send     = dac_send_q;
  assign bus.o_Overrun      = overrun_q;
  assign bus.o_Busy         = busy_q;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// tb/tb_harmonic_sequencer.sv - directed bench for harmonic_sequencer with N=4, SAMPLEINTERVAL=100
module tb_harmonic_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fth_mode = 1'b0;
  int   cyc;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  harmonic_sequencer_if hs_if ();

  assign hs_if.i_Freq_Too_High = fth_mode & (hs_if.o_Harmonic != 8'd0);

  harmonic_sequencer #(
    .NO_OF_HARMONICS(8'd4),
    .SAMPLEINTERVAL (16'd100)
  ) dut (
    .i_Clock  (clk),
    .i_Reset_n(rst_n),
    .bus      (hs_if.master)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic       comb_en;
    logic       muted;
    logic       fth;
    int         n_add;
    logic [7:0] seq;
    int         max_h;
    int         visits;
    int         latch_ofs;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [17:0] all_outs();
    return {hs_if.o_Harmonic, hs_if.o_Next_Sample, hs_if.o_Start_Mult, hs_if.o_Restart_Mult,
            hs_if.o_Adder_Start, hs_if.o_Adder_Clear, hs_if.o_Latch_Totals, hs_if.o_DAC_Send,
            hs_if.o_Overrun, hs_if.o_Busy};
  endfunction

  task automatic wait_dac(output int t);
    t = -1;
    for (int n = 0; n < 250; n++) begin
      @(negedge clk);
      if (hs_if.o_DAC_Send) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("dac_timeout", 0, 1);
  endtask

  // Called on the DAC_Send cycle; observes one frame up to its latch pulse.
  task automatic run_frame(input int d, output int n_add, output logic [7:0] seq, output int max_h,
                           output int visits, output int ns, output int latch_ofs,
                           output logic clear_ok, output logic busy_at_latch, output logic pulse_ok);
    n_add = 0; seq = 8'd0; max_h = 0; visits = 0; ns = 0; latch_ofs = -1;
    clear_ok = 1'b0; busy_at_latch = 1'b1; pulse_ok = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1 && (hs_if.o_DAC_Send || hs_if.o_Restart_Mult)) pulse_ok = 1'b0;
      if (hs_if.o_Adder_Start == 2'b11) pulse_ok = 1'b0;
      if (hs_if.o_Adder_Start != 2'b00) begin
        n_add++;
        seq = {seq[5:0], hs_if.o_Adder_Start};
      end
      if (hs_if.o_Start_Mult) visits++;
      if (hs_if.o_Next_Sample) ns++;
      if (int'(hs_if.o_Harmonic) > max_h) max_h = int'(hs_if.o_Harmonic);
      if (hs_if.o_Latch_Totals) begin
        latch_ofs = cyc - d;
        clear_ok = hs_if.o_Adder_Clear;
        busy_at_latch = hs_if.o_Busy;
        break;
      end
    end
    if (latch_ofs < 0) check("latch_timeout", 0, 1);
  endtask

  initial begin
    int t, t_prev, n_add, max_h, visits, ns, lofs;
    logic [7:0] seq;
    logic clear_ok, busy_l, pulse_ok;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 4, 8'b01100110, 3, 4, 21};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1, 8'b00000001, 3, 4, 15};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 2, 8'b00000110, 1, 2, 11};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 4, 8'b01100110, 3, 4, 21};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 4, 8'b01100110, 3, 4, 21};

    hs_if.i_Sample_Ready = 1'b1;
    hs_if.i_Mult_Ready   = 1'b1;
    hs_if.i_Comb_Muted   = 1'b0;
    hs_if.i_Comb_Enable  = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(all_outs()), 0);
    rst_n = 1'b1;

    wait_dac(t);
    check("first_dac_cycle", t, 100);
    check("first_overrun", hs_if.o_Overrun, 0);
    check("send_harmonic", hs_if.o_Harmonic, 0);
    check("send_restart", hs_if.o_Restart_Mult, 1);
    wait_dac(t);
    check("second_dac_cycle", t, 200);
    t_prev = t;

    for (int v = 0; v < 5; v++) begin
      hs_if.i_Comb_Enable = vecs[v].comb_en;
      hs_if.i_Comb_Muted  = vecs[v].muted;
      fth_mode            = vecs[v].fth;
      wait_dac(t);
      check($sformatf("v%0d_period", v), t - t_prev, 100);
      check($sformatf("v%0d_overrun", v), hs_if.o_Overrun, 0);
      t_prev = t;
      run_frame(t, n_add, seq, max_h, visits, ns, lofs, clear_ok, busy_l, pulse_ok);
      check($sformatf("v%0d_adds", v), n_add, vecs[v].n_add);
      check($sformatf("v%0d_adder_bits", v), seq, vecs[v].seq);
      check($sformatf("v%0d_max_harmonic", v), max_h, vecs[v].max_h);
      check($sformatf("v%0d_start_mult", v), visits, vecs[v].visits);
      check($sformatf("v%0d_next_sample", v), ns, vecs[v].visits);
      check($sformatf("v%0d_latch_ofs", v), lofs, vecs[v].latch_ofs);
      check($sformatf("v%0d_clear_with_latch", v), clear_ok, 1);
      check($sformatf("v%0d_busy_at_done", v), busy_l, 0);
      check($sformatf("v%0d_pulses", v), pulse_ok, 1);
    end
    hs_if.i_Comb_Enable = 1'b0;
    hs_if.i_Comb_Muted  = 1'b0;
    fth_mode            = 1'b0;

    // Stalled sample lookup: the tick must abort the frame without slipping the cadence.
    hs_if.i_Sample_Ready = 1'b0;
    wait_dac(t);
    t_prev = t;
    run_frame(t, n_add, seq, max_h, visits, ns, lofs, clear_ok, busy_l, pulse_ok);
    check("abort_latch_ofs", lofs, 100);
    check("abort_adds", n_add, 0);
    check("abort_clear", clear_ok, 1);
    hs_if.i_Sample_Ready = 1'b1;
    wait_dac(t);
    check("abort_dac_ofs", t - t_prev, 101);
    check("abort_overrun", hs_if.o_Overrun, 1);
    run_frame(t, n_add, seq, max_h, visits, ns, lofs, clear_ok, busy_l, pulse_ok);
    check("recover_adds", n_add, 4);
    check("recover_latch_ofs", lofs, 21);
    wait_dac(t);
    check("recover_period", t - t_prev, 200);
    check("recover_overrun", hs_if.o_Overrun, 0);

    // Reset asserted mid-frame while waiting on the sample lookup.
    hs_if.i_Sample_Ready = 1'b0;
    wait_dac(t);
    repeat (3) @(negedge clk);
    check("midframe_busy", hs_if.o_Busy, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", 32'(all_outs()), 0);
    repeat (2) @(negedge clk);
    hs_if.i_Sample_Ready = 1'b1;
    rst_n = 1'b1;
    wait_dac(t);
    check("post_reset_dac_cycle", t, 100);
    check("post_reset_overrun", hs_if.o_Overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
